// File: rtl/big_inport_rx.sv
// Wide-value receiver: captures a strobed fabric word and serializes it MSB-first
// as 8-bit bytes for the processor inport bus.
module big_inport_rx #(
  parameter int WIDTH = 26
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_vb,
  input  logic             i_vb_wr,
  input  logic             i_latch,
  input  logic             i_rd,
  output logic [7:0]       o_data,
  output logic             o_avail,
  output logic             o_overrun,
  output logic             o_busy
);

  // state | meaning
  // IDLE  | no bytes pending, o_data held at 0x00
  // READ  | count bytes remain, o_data shows the current one
  localparam int NBYTES = (WIDTH + 7) / 8;
  localparam int SW     = 8 * NBYTES;
  localparam int CW     = $clog2(NBYTES + 1);

  typedef enum logic {IDLE, READ} state_t;

  state_t           state;
  logic [WIDTH-1:0] holding;
  logic [SW-1:0]    hold_ext;
  logic [SW-1:0]    shift;
  logic [CW-1:0]    count;

  // Zero-extend to whole bytes so the first byte carries the leftover top bits.
  always_comb begin
    hold_ext = '0;
    hold_ext[WIDTH-1:0] = holding;
  end

  // Availability/overrun tracker; a latch in the same cycle as a write masks overrun.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      holding   <= '0;
      o_avail   <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      if (i_vb_wr) holding <= i_vb;
      if (i_vb_wr)      o_avail <= 1'b1;
      else if (i_latch) o_avail <= 1'b0;
      if (i_latch)                   o_overrun <= 1'b0;
      else if (i_vb_wr && o_avail)   o_overrun <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state  <= IDLE;
      shift  <= '0;
      count  <= '0;
      o_data <= 8'h00;
      o_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_latch) begin
            state  <= READ;
            shift  <= hold_ext;
            count  <= CW'(NBYTES);
            o_data <= hold_ext[SW-1 -: 8];
            o_busy <= 1'b1;
          end
        end
        READ: begin
          if (i_latch) begin
            shift  <= hold_ext;
            count  <= CW'(NBYTES);
            o_data <= hold_ext[SW-1 -: 8];
            o_busy <= 1'b1;
          end else if (i_rd) begin
            shift <= shift << 8;
            count <= count - CW'(1);
            if (count == CW'(1)) begin
              state  <= IDLE;
              o_data <= 8'h00;
              o_busy <= 1'b0;
            end else begin
              o_data <= shift[SW-9 -: 8];
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_big_inport_rx.sv
// Scoreboard bench for big_inport_rx at WIDTH=26: expected bytes are queued at latch time.
module tb_big_inport_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [25:0] vb = '0;
  logic        vb_wr = 1'b0;
  logic        latch = 1'b0;
  logic        rd = 1'b0;
  logic [7:0]  data;
  logic        avail, ovr, busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  big_inport_rx #(.WIDTH(26)) dut (
    .i_clk(clk), .i_rst(rst), .i_vb(vb), .i_vb_wr(vb_wr), .i_latch(latch), .i_rd(rd),
    .o_data(data), .o_avail(avail), .o_overrun(ovr), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic pulse(input logic w, input logic l, input logic r, input logic [25:0] v);
    @(negedge clk);
    vb = v; vb_wr = w; latch = l; rd = r;
    @(posedge clk);
    #1;
    vb_wr = 1'b0; latch = 1'b0; rd = 1'b0;
  endtask

  // Expected readout for a latched value: four bytes MSB-first, then idle 0x00.
  task automatic push_val(input logic [25:0] v);
    logic [31:0] w;
    w = {6'b0, v};
    exp_q.delete();
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
    exp_q.push_back(8'h00);
  endtask

  task automatic test_reset();
    #12;
    n_tests++;
    if (data !== 8'h00 || avail !== 1'b0 || busy !== 1'b0 || ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in: data=%h avail=%b busy=%b ovr=%b, want 00 0 0 0", data, avail, busy, ovr);
    end
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (data !== 8'h00 || avail !== 1'b0 || busy !== 1'b0 || ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: data=%h avail=%b busy=%b ovr=%b, want 00 0 0 0", data, avail, busy, ovr);
    end
  endtask

  task automatic test_basic();
    logic [7:0] e;
    pulse(1, 0, 0, 26'h2ABCDEF);
    n_tests++;
    if (avail !== 1'b1) begin n_fail++; $display("FAIL basic_avail1: got %b want 1", avail); end
    push_val(26'h2ABCDEF);
    pulse(0, 1, 0, '0);
    n_tests++;
    if (avail !== 1'b0) begin n_fail++; $display("FAIL basic_avail0: got %b want 0", avail); end
    for (int i = 0; i < 5; i++) begin
      e = exp_q.pop_front();
      n_tests++;
      if (data !== e || busy !== (i < 4)) begin
        n_fail++;
        $display("FAIL basic_byte%0d: data=%h busy=%b want data=%h busy=%b", i, data, busy, e, (i < 4));
      end
      pulse(0, 0, 1, '0);
    end
    n_tests++;
    if (data !== 8'h00 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_extra_rd: data=%h busy=%b want 00 0", data, busy);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] e;
    pulse(1, 0, 0, 26'h1234567);
    n_tests++;
    if (ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_first: got %b want 0", ovr); end
    pulse(1, 0, 0, 26'h3FFFFFF);
    n_tests++;
    if (ovr !== 1'b1 || avail !== 1'b1) begin
      n_fail++; $display("FAIL ovr_set: ovr=%b avail=%b want 1 1", ovr, avail);
    end
    push_val(26'h3FFFFFF);
    pulse(0, 1, 0, '0);
    n_tests++;
    if (ovr !== 1'b0 || avail !== 1'b0) begin
      n_fail++; $display("FAIL ovr_clear: ovr=%b avail=%b want 0 0", ovr, avail);
    end
    for (int i = 0; i < 5; i++) begin
      e = exp_q.pop_front();
      n_tests++;
      if (data !== e || busy !== (i < 4)) begin
        n_fail++;
        $display("FAIL ovr_byte%0d: data=%h busy=%b want data=%h busy=%b", i, data, busy, e, (i < 4));
      end
      if (i < 4) pulse(0, 0, 1, '0);
    end
  endtask

  task automatic test_wr_with_latch();
    logic [7:0] e;
    pulse(1, 0, 0, 26'h2ABCDEF);
    push_val(26'h2ABCDEF);
    pulse(1, 1, 0, 26'h0000001);
    n_tests++;
    if (avail !== 1'b1 || ovr !== 1'b0) begin
      n_fail++; $display("FAIL wrl_flags: avail=%b ovr=%b want 1 0", avail, ovr);
    end
    for (int i = 0; i < 5; i++) begin
      e = exp_q.pop_front();
      n_tests++;
      if (data !== e || busy !== (i < 4)) begin
        n_fail++;
        $display("FAIL wrl_old_byte%0d: data=%h busy=%b want data=%h busy=%b", i, data, busy, e, (i < 4));
      end
      if (i < 4) pulse(0, 0, 1, '0);
    end
    push_val(26'h0000001);
    pulse(0, 1, 0, '0);
    n_tests++;
    if (avail !== 1'b0 || ovr !== 1'b0) begin
      n_fail++; $display("FAIL wrl_relatch: avail=%b ovr=%b want 0 0", avail, ovr);
    end
    for (int i = 0; i < 5; i++) begin
      e = exp_q.pop_front();
      n_tests++;
      if (data !== e || busy !== (i < 4)) begin
        n_fail++;
        $display("FAIL wrl_new_byte%0d: data=%h busy=%b want data=%h busy=%b", i, data, busy, e, (i < 4));
      end
      if (i < 4) pulse(0, 0, 1, '0);
    end
  endtask

  task automatic test_abort();
    logic [7:0] e;
    pulse(1, 0, 0, 26'h2ABCDEF);
    pulse(0, 1, 0, '0);
    pulse(0, 0, 1, '0);
    n_tests++;
    if (data !== 8'hAB) begin n_fail++; $display("FAIL abort_second: got %h want ab", data); end
    pulse(0, 1, 0, '0);
    n_tests++;
    if (data !== 8'h02 || busy !== 1'b1) begin
      n_fail++; $display("FAIL abort_restart: data=%h busy=%b want 02 1", data, busy);
    end
    push_val(26'h2ABCDEF);
    pulse(0, 1, 1, '0);
    for (int i = 0; i < 5; i++) begin
      e = exp_q.pop_front();
      n_tests++;
      if (data !== e || busy !== (i < 4)) begin
        n_fail++;
        $display("FAIL abort_byte%0d: data=%h busy=%b want data=%h busy=%b", i, data, busy, e, (i < 4));
      end
      if (i < 4) pulse(0, 0, 1, '0);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] e;
    pulse(0, 1, 0, '0);
    pulse(0, 0, 1, '0);
    pulse(1, 0, 0, 26'h0000155);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (data !== 8'h00 || avail !== 1'b0 || busy !== 1'b0 || ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst: data=%h avail=%b busy=%b ovr=%b want 00 0 0 0", data, avail, busy, ovr);
    end
    #2 rst = 1'b1;
    pulse(0, 0, 1, '0);
    n_tests++;
    if (data !== 8'h00 || busy !== 1'b0) begin
      n_fail++; $display("FAIL async_rd_after: data=%h busy=%b want 00 0", data, busy);
    end
    push_val(26'h0);
    pulse(0, 1, 0, '0);
    for (int i = 0; i < 5; i++) begin
      e = exp_q.pop_front();
      n_tests++;
      if (data !== e || busy !== (i < 4)) begin
        n_fail++;
        $display("FAIL async_byte%0d: data=%h busy=%b want data=%h busy=%b", i, data, busy, e, (i < 4));
      end
      if (i < 4) pulse(0, 0, 1, '0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_wr_with_latch();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
